cmem_arbiter: RTL

Two-to-one memory arbiter between the CPU's instruction port (a) and data port (b) and a single shared physical memory port. It accepts level-held read/write requests from both CPU ports, grants one at a time, and latches the granted command onto the physical port. It routes the memory response back to the granted requester. It sits between `cpu` and the unified cache/memory.

---
 rtl/cmem_arbiter_if.sv | 47 ++++
 rtl/cmem_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/cmem_arbiter_if.sv
// Bundle of CPU-side (ports a and b) and physical-memory-side signals for cmem_arbiter.
// slave: the arbiter's view; master: the environment (CPU ports plus memory model).
interface cmem_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             cmem_read_a;
    logic             cmem_write_a;
    logic [3:0]       cmem_byte_enable_a;
    logic [WIDTH-1:0] cmem_address_a;
    logic [WIDTH-1:0] cmem_wdata_a;
    logic             cmem_resp_a;
    logic [WIDTH-1:0] cmem_rdata_a;

    logic             cmem_read_b;
    logic             cmem_write_b;
    logic [3:0]       cmem_byte_enable_b;
    logic [WIDTH-1:0] cmem_address_b;
    logic [WIDTH-1:0] cmem_wdata_b;
    logic             cmem_resp_b;
    logic [WIDTH-1:0] cmem_rdata_b;

    logic             pmem_read;
    logic             pmem_write;
    logic [3:0]       pmem_byte_enable;
    logic [WIDTH-1:0] pmem_address;
    logic [WIDTH-1:0] pmem_wdata;
    logic             pmem_resp;
    logic [WIDTH-1:0] pmem_rdata;

    modport slave (
        input  cmem_read_a, cmem_write_a, cmem_byte_enable_a, cmem_address_a, cmem_wdata_a,
        output cmem_resp_a, cmem_rdata_a,
        input  cmem_read_b, cmem_write_b, cmem_byte_enable_b, cmem_address_b, cmem_wdata_b,
        output cmem_resp_b, cmem_rdata_b,
        output pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata
    );

    modport master (
        output cmem_read_a, cmem_write_a, cmem_byte_enable_a, cmem_address_a, cmem_wdata_a,
        input  cmem_resp_a, cmem_rdata_a,
        output cmem_read_b, cmem_write_b, cmem_byte_enable_b, cmem_address_b, cmem_wdata_b,
        input  cmem_resp_b, cmem_rdata_b,
        input  pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata
    );
endinterface

// File: rtl/cmem_arbiter.sv
// Two-to-one arbiter: CPU instruction port (a) and data port (b) onto one physical memory port.
// Tie policy: CMEM_ARB_ROUND_ROBIN_EN selects round-robin; otherwise b has fixed priority.
module cmem_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    cmem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             cmd_read_q, cmd_read_d;
    logic             cmd_write_q, cmd_write_d;
    logic [3:0]       cmd_be_q, cmd_be_d;
    logic [WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;

    logic req_a, req_b, tie_b, grant_b, busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b0;
            cmd_read_q   <= 1'b0;
            cmd_write_q  <= 1'b0;
            cmd_be_q     <= '0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_read_q   <= cmd_read_d;
            cmd_write_q  <= cmd_write_d;
            cmd_be_q     <= cmd_be_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_read_d   = cmd_read_q;
        cmd_write_d  = cmd_write_q;
        cmd_be_d     = cmd_be_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;

        req_a = bus.cmem_read_a | bus.cmem_write_a;
        req_b = bus.cmem_read_b | bus.cmem_write_b;
`ifdef CMEM_ARB_ROUND_ROBIN_EN
        tie_b = ~last_grant_q;
`else
        // Fixed priority: b wins; last_grant is tracked but never steers the choice.
        tie_b = 1'b1 | last_grant_q;
`endif
        grant_b = req_b & (~req_a | tie_b);

        unique case (state_q)
            IDLE: begin
                if (req_a | req_b) begin
                    state_d      = grant_b ? SERVE_B : SERVE_A;
                    last_grant_d = grant_b;
                    // Write dominates when a port raises read and write together.
                    if (grant_b) begin
                        cmd_write_d = bus.cmem_write_b;
                        cmd_read_d  = bus.cmem_read_b & ~bus.cmem_write_b;
                        cmd_be_d    = bus.cmem_byte_enable_b;
                        cmd_addr_d  = bus.cmem_address_b;
                        cmd_wdata_d = bus.cmem_wdata_b;
                    end else begin
                        cmd_write_d = bus.cmem_write_a;
                        cmd_read_d  = bus.cmem_read_a & ~bus.cmem_write_a;
                        cmd_be_d    = bus.cmem_byte_enable_a;
                        cmd_addr_d  = bus.cmem_address_a;
                        cmd_wdata_d = bus.cmem_wdata_a;
                    end
                end
            end
            SERVE_A, SERVE_B: begin
                if (bus.pmem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    assign bus.pmem_read        = busy & cmd_read_q;
    assign bus.pmem_write       = busy & cmd_write_q;
    assign bus.pmem_byte_enable = cmd_be_q;
    assign bus.pmem_address     = cmd_addr_q;
    assign bus.pmem_wdata       = cmd_wdata_q;

    assign bus.cmem_resp_a  = (state_q == SERVE_A) & bus.pmem_resp;
    assign bus.cmem_resp_b  = (state_q == SERVE_B) & bus.pmem_resp;
    assign bus.cmem_rdata_a = bus.pmem_rdata;
    assign bus.cmem_rdata_b = bus.pmem_rdata;

endmodule
